// File: rtl/seq_addsub_engine_pkg.sv
// Shared types and constants for the digit-serial add/subtract engine.
// No logic; state encoding and op-field bit positions only.
// Not applicable (no handshakes).
package seq_addsub_engine_pkg;

  // Engine sequence: IDLE -> LOAD -> BUSY -> DONE -> IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Bit positions within the 2-bit op field
  localparam int OP_SUB = 0;  // 1 = subtract (right operand inverted, carry-in set)
  localparam int OP_ACC = 1;  // 1 = left operand is the previous result

endpackage

// File: rtl/seq_addsub_engine_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice used once per BUSY cycle.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry from the slice LSB upward
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];  // carry into the slice's top bit, used for signed overflow

endmodule

// File: rtl/seq_addsub_engine.sv
// Multi-cycle add/sub/accumulate engine processing DIGIT bits per cycle.
// Latency: start accepted at edge t0 -> result and done valid after edge t0 + WIDTH/DIGIT + 2.
// Backpressure: none; start and wr_en are only honoured in IDLE, otherwise dropped.
module seq_addsub_engine
  import seq_addsub_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             done,
  output logic [2:0]       status
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_addsub_engine: WIDTH must be a multiple of DIGIT");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("seq_addsub_engine: WIDTH must be at least 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] left_q, left_d, right_q, right_d, acc_q, acc_d;
  logic             cy_q, cy_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, overflow_q, overflow_d;
  logic             done_q, done_d, ready_q, ready_d, busy_q, busy_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout, dig_cmsb;
  logic [WIDTH+DIGIT-1:0] acc_cat;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (left_q[DIGIT-1:0]),
    .b     (right_q[DIGIT-1:0]),
    .cin   (cy_q),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // New sum digit enters at the MSB end; the concatenation also covers DIGIT == WIDTH
  assign acc_cat = {dig_s, acc_q};

  // Next-state, datapath and flag updates; abort overrides the sequence but keeps the last result
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    left_d     = left_q;
    right_d    = right_q;
    acc_d      = acc_q;
    cy_d       = cy_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          if (wr_sel) b_d = wr_data;
          else        a_d = wr_data;
        end
        if (start) begin
          op_d    = op;
          done_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        left_d  = op_q[OP_ACC] ? result_q : a_q;
        right_d = op_q[OP_SUB] ? ~b_q : b_q;
        cy_d    = op_q[OP_SUB];
        cnt_d   = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        left_d  = left_q >> DIGIT;
        right_d = right_q >> DIGIT;
        acc_d   = acc_cat[WIDTH+DIGIT-1:DIGIT];
        cy_d    = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          ovf_d   = dig_cmsb ^ dig_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d   = acc_q;
        carry_d    = cy_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      ready_d    = 1'b0;
      done_d     = 1'b0;
      result_d   = result_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
    end
  end

  // State and datapath registers; reset clears everything including the visible result
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      left_q     <= '0;
      right_q    <= '0;
      acc_q      <= '0;
      cy_q       <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      left_q     <= left_d;
      right_q    <= right_d;
      acc_q      <= acc_d;
      cy_q       <= cy_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign status   = {ready_q, busy_q, done_q};

endmodule

// File: tb/tb_seq_addsub_engine.sv
// Directed bench for seq_addsub_engine (8/1 and 16/4 configurations).
// Expected results are queued at start; monitors pop them on each done rising edge.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_seq_addsub_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic       wr_en8, wr_sel8, start8, abort8;
  logic [7:0] wr_data8;
  logic [1:0] op8;
  logic [7:0] result8;
  logic       carry8, ovf8, done8;
  logic [2:0] status8;

  logic        wr_en16, wr_sel16, start16, abort16;
  logic [15:0] wr_data16;
  logic [1:0]  op16;
  logic [15:0] result16;
  logic        carry16, ovf16, done16;
  logic [2:0]  status16;

  seq_addsub_engine #(.WIDTH(8), .DIGIT(1)) dut8 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wr_en(wr_en8), .wr_sel(wr_sel8), .wr_data(wr_data8),
    .op(op8), .start(start8), .abort(abort8), .result(result8), .carry(carry8),
    .overflow(ovf8), .done(done8), .status(status8)
  );

  seq_addsub_engine #(.WIDTH(16), .DIGIT(4)) dut16 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wr_en(wr_en16), .wr_sel(wr_sel16), .wr_data(wr_data16),
    .op(op16), .start(start16), .abort(abort16), .result(result16), .carry(carry16),
    .overflow(ovf16), .done(done16), .status(status16)
  );

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    int          t0;
    int          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Completion monitor, 8-bit engine
  logic done8_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (done8 && !done8_prev) begin
      if (q8.size() == 0) begin
        total = total + 1;
        $display("FAIL d8 completion: got unexpected done, expected none");
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("d8 result", 32'(result8), 32'(e.res[7:0]));
        chk("d8 carry", 32'(carry8), 32'(e.c));
        chk("d8 overflow", 32'(ovf8), 32'(e.v));
        chk("d8 latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
    done8_prev = done8;
  end

  // Completion monitor, 16-bit engine
  logic done16_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (done16 && !done16_prev) begin
      if (q16.size() == 0) begin
        total = total + 1;
        $display("FAIL d16 completion: got unexpected done, expected none");
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("d16 result", 32'(result16), 32'(e.res));
        chk("d16 carry", 32'(carry16), 32'(e.c));
        chk("d16 overflow", 32'(ovf16), 32'(e.v));
        chk("d16 latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
    done16_prev = done16;
  end

  task automatic wr8(input logic sel, input logic [7:0] d);
    @(negedge clk);
    wr_en8 = 1'b1; wr_sel8 = sel; wr_data8 = d;
    @(negedge clk);
    wr_en8 = 1'b0;
  endtask

  task automatic push8(input logic [7:0] r, input logic c, input logic v);
    exp_t e;
    e.res = 16'(r); e.c = c; e.v = v; e.t0 = cyc; e.lat = 10;
    q8.push_back(e);
  endtask

  task automatic wait8(input string nm);
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      total = total + 1;
      $display("FAIL %s timeout: got no completion, expected done within 40 cycles", nm);
      q8.delete();
    end else begin
      chk({nm, " status done"}, 32'(status8), 32'(3'b001));
    end
  endtask

  // Called just after a falling edge; op is scrambled after acceptance to show it is latched
  task automatic go8(input logic [1:0] o, input logic [7:0] r, input logic c, input logic v,
                     input string nm);
    start8 = 1'b1; op8 = o;
    @(negedge clk);
    start8 = 1'b0; op8 = ~o;
    push8(r, c, v);
    chk({nm, " done cleared"}, 32'(done8), 32'(0));
    chk({nm, " status load"}, 32'(status8), 32'(3'b100));
    @(negedge clk);
    chk({nm, " status busy"}, 32'(status8), 32'(3'b010));
    wait8(nm);
  endtask

  initial begin
    exp_t e;
    wr_en8 = 0; wr_sel8 = 0; wr_data8 = '0; op8 = '0; start8 = 0; abort8 = 0;
    wr_en16 = 0; wr_sel16 = 0; wr_data16 = '0; op16 = '0; start16 = 0; abort16 = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset result8", 32'(result8), 32'(0));
    chk("reset flags8", 32'({carry8, ovf8, done8, status8}), 32'(0));
    chk("reset result16", 32'(result16), 32'(0));
    chk("reset status16", 32'(status16), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add, then accumulate chain starting from result 8
    wr8(0, 8'd5); wr8(1, 8'd3);
    go8(2'b00, 8'd8, 1'b0, 1'b0, "add 5+3");
    wr8(1, 8'd8);
    go8(2'b10, 8'd16, 1'b0, 1'b0, "acc +8");
    go8(2'b10, 8'd24, 1'b0, 1'b0, "acc +8 again");
    wr8(1, 8'd4);
    go8(2'b11, 8'd20, 1'b1, 1'b0, "acc -4");

    // Subtraction with and without borrow
    wr8(0, 8'd3); wr8(1, 8'd5);
    go8(2'b01, 8'hFE, 1'b0, 1'b0, "sub 3-5");
    wr8(0, 8'd5); wr8(1, 8'd3);
    go8(2'b01, 8'h02, 1'b1, 1'b0, "sub 5-3");

    // Signed overflow and unsigned wrap
    wr8(0, 8'h7F); wr8(1, 8'h01);
    go8(2'b00, 8'h80, 1'b0, 1'b1, "add 7F+1");
    wr8(0, 8'hFF);
    go8(2'b00, 8'h00, 1'b1, 1'b0, "add FF+1");

    // start and a write to A mid-BUSY are dropped
    wr8(0, 8'h10); wr8(1, 8'h01);
    start8 = 1'b1; op8 = 2'b00;
    @(negedge clk);
    start8 = 1'b0;
    push8(8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midbusy status", 32'(status8), 32'(3'b010));
    start8 = 1'b1; wr_en8 = 1'b1; wr_sel8 = 1'b0; wr_data8 = 8'hAA;
    @(negedge clk);
    start8 = 1'b0; wr_en8 = 1'b0;
    wait8("ignored inputs");
    repeat (15) @(negedge clk);
    go8(2'b00, 8'h11, 1'b0, 1'b0, "A unchanged");

    // Abort during the fourth BUSY cycle
    wr8(0, 8'h01); wr8(1, 8'h01);
    start8 = 1'b1; op8 = 2'b00;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-abort status", 32'(status8), 32'(3'b010));
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    chk("abort status", 32'(status8), 32'(3'b000));
    chk("abort result kept", 32'(result8), 32'(8'h11));
    chk("abort flags kept", 32'({carry8, ovf8}), 32'(0));
    repeat (15) @(negedge clk);
    chk("post-abort status", 32'(status8), 32'(3'b000));

    // Reset mid-BUSY clears outputs immediately
    start8 = 1'b1; op8 = 2'b00;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset result", 32'(result8), 32'(0));
    chk("midreset status", 32'(status8), 32'(0));
    chk("midreset flags", 32'({carry8, ovf8, done8}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // 16-bit engine, 4 bits per cycle
    wr_en16 = 1'b1; wr_sel16 = 1'b0; wr_data16 = 16'h1234;
    @(negedge clk);
    wr_sel16 = 1'b1; wr_data16 = 16'h0FFF;
    @(negedge clk);
    wr_en16 = 1'b0; start16 = 1'b1; op16 = 2'b00;
    @(negedge clk);
    start16 = 1'b0; op16 = 2'b11;
    e.res = 16'h2233; e.c = 1'b0; e.v = 1'b0; e.t0 = cyc; e.lat = 6;
    q16.push_back(e);
    for (int i = 0; i < 30 && q16.size() != 0; i++) @(negedge clk);
    chk("d16 first pending", 32'(q16.size()), 32'(0));

    // Write and start in the same IDLE cycle: LOAD sees the new A
    wr_en16 = 1'b1; wr_sel16 = 1'b0; wr_data16 = 16'h0001; start16 = 1'b1; op16 = 2'b00;
    @(negedge clk);
    wr_en16 = 1'b0; start16 = 1'b0;
    e.res = 16'h1000; e.c = 1'b0; e.v = 1'b0; e.t0 = cyc; e.lat = 6;
    q16.push_back(e);
    for (int i = 0; i < 30 && q16.size() != 0; i++) @(negedge clk);
    chk("d16 second pending", 32'(q16.size()), 32'(0));
    chk("d16 status done", 32'(status16), 32'(3'b001));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
